// File: rtl/scm_1r1w_port_arbiter_if.sv
// Requester-side bus of the 1R1W register-file port arbiter.
// One request channel per port, packed port-major; the read-data return is
// a single shared word qualified by a one-hot valid.
interface scm_1r1w_port_arbiter_if #(
    parameter int N_PORTS    = 4,
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
);
    logic [N_PORTS-1:0]            req_i;
    logic [N_PORTS-1:0]            we_i;
    logic [N_PORTS*ADDR_WIDTH-1:0] addr_i;
    logic [N_PORTS*DATA_WIDTH-1:0] wdata_i;
    logic [N_PORTS-1:0]            gnt_o;
    logic [N_PORTS-1:0]            r_valid_o;
    logic [DATA_WIDTH-1:0]         r_rdata_o;

    // Requesters drive the request fields and observe grant / read return.
    modport master (
        output req_i, we_i, addr_i, wdata_i,
        input  gnt_o, r_valid_o, r_rdata_o
    );

    // The arbiter consumes requests and produces grant / read return.
    modport slave (
        input  req_i, we_i, addr_i, wdata_i,
        output gnt_o, r_valid_o, r_rdata_o
    );
endinterface

// File: rtl/scm_1r1w_port_arbiter.sv
// Arbiter sharing one 1-read/1-write latch-based register file among
// N_PORTS requesters. Each cycle grants at most one write and one read using
// independent round-robin pointers; read data returns one cycle after grant.
// Because the latch array updates mid-cycle, a read to the address being
// written in the same cycle is held off one cycle (the write wins).
// Optional macro SCM_ARB_RAW_BYPASS_EN: instead of holding off the colliding
// read, grant it and forward the write data on the following cycle.
module scm_1r1w_port_arbiter #(
    parameter int N_PORTS    = 4,
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    scm_1r1w_port_arbiter_if.slave bus,
    output logic                  rf_ReadEnable_o,
    output logic [ADDR_WIDTH-1:0] rf_ReadAddr_o,
    input  logic [DATA_WIDTH-1:0] rf_ReadData_i,
    output logic                  rf_WriteEnable_o,
    output logic [ADDR_WIDTH-1:0] rf_WriteAddr_o,
    output logic [DATA_WIDTH-1:0] rf_WriteData_o
);

    localparam int PTR_W = $clog2(N_PORTS);
    typedef logic [PTR_W-1:0] ptr_t;

    // First candidate at or after ptr, wrapping modulo N_PORTS.
    function automatic void rr_pick(
        input  logic [N_PORTS-1:0] cand,
        input  ptr_t               ptr,
        output logic               found,
        output ptr_t               idx
    );
        int k;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            k = int'(ptr) + i;
            if (k >= N_PORTS) k = k - N_PORTS;
            if (!found && cand[k]) begin
                found = 1'b1;
                idx   = ptr_t'(k);
            end
        end
    endfunction

    // Pointer value one past the winner, wrapping modulo N_PORTS.
    function automatic ptr_t ptr_after(input ptr_t idx);
        int k;
        k = int'(idx) + 1;
        if (k >= N_PORTS) k = 0;
        return ptr_t'(k);
    endfunction

    logic [ADDR_WIDTH-1:0] addr  [N_PORTS];
    logic [DATA_WIDTH-1:0] wdata [N_PORTS];

    for (genvar p = 0; p < N_PORTS; p++) begin : g_unpack
        assign addr[p]  = bus.addr_i[p*ADDR_WIDTH +: ADDR_WIDTH];
        assign wdata[p] = bus.wdata_i[p*DATA_WIDTH +: DATA_WIDTH];
    end

    ptr_t               wr_ptr_q, rd_ptr_q, rid_q;
    logic               rvalid_q;
    logic [N_PORTS-1:0] wr_cand, rd_cand, coll_mask;
    logic               wr_found, rd_found;
    ptr_t               wr_idx, rd_idx;
    logic [N_PORTS-1:0] gnt, r_valid;
    logic [DATA_WIDTH-1:0] r_rdata;

    // Write arbitration and register-file write port.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first,
        // so no path through the block leaves a value held (no latch).
        rf_WriteEnable_o = 1'b0;
        rf_WriteAddr_o   = '0;
        rf_WriteData_o   = '0;
        wr_cand = bus.req_i & bus.we_i;
        rr_pick(wr_cand, wr_ptr_q, wr_found, wr_idx);
        if (wr_found) begin
            rf_WriteEnable_o = 1'b1;
            rf_WriteAddr_o   = addr[wr_idx];
            rf_WriteData_o   = wdata[wr_idx];
        end
    end

    // Read arbitration; readers of the address being written are masked
    // unless the bypass path forwards the write data instead.
    always_comb begin
        coll_mask       = '0;
        rf_ReadEnable_o = 1'b0;
        rf_ReadAddr_o   = '0;
`ifndef SCM_ARB_RAW_BYPASS_EN
        for (int p = 0; p < N_PORTS; p++) begin
            coll_mask[p] = wr_found && (addr[p] == rf_WriteAddr_o);
        end
`endif
        rd_cand = bus.req_i & ~bus.we_i & ~coll_mask;
        rr_pick(rd_cand, rd_ptr_q, rd_found, rd_idx);
        if (rd_found) begin
            rf_ReadEnable_o = 1'b1;
            rf_ReadAddr_o   = addr[rd_idx];
        end
    end

    // Per-port grant and one-hot read-valid decode.
    always_comb begin
        gnt     = '0;
        r_valid = '0;
        if (wr_found) gnt[wr_idx] = 1'b1;
        if (rd_found) gnt[rd_idx] = 1'b1;
        if (rvalid_q) r_valid[rid_q] = 1'b1;
    end

    // Round-robin pointers advance past each winner; read id/valid register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            rvalid_q <= 1'b0;
            rid_q    <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every
            // flop samples pre-edge values regardless of statement order.
            if (wr_found) wr_ptr_q <= ptr_after(wr_idx);
            if (rd_found) begin
                rd_ptr_q <= ptr_after(rd_idx);
                rid_q    <= rd_idx;
            end
            rvalid_q <= rd_found;
        end
    end

`ifdef SCM_ARB_RAW_BYPASS_EN
    logic                  byp_hit, byp_sel_q;
    logic [DATA_WIDTH-1:0] byp_data_q;

    assign byp_hit = wr_found && rd_found && (rf_ReadAddr_o == rf_WriteAddr_o);

    // Remember that the next read return must come from the forwarded word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) byp_sel_q <= 1'b0;
        else        byp_sel_q <= byp_hit;
    end

    // Capture the write word on a same-address read/write.
    always_ff @(posedge clk) begin
        // NOTE: pure data register, left unreset; it is only observed
        // while byp_sel_q (which is reset) selects it.
        if (byp_hit) byp_data_q <= rf_WriteData_o;
    end

    assign r_rdata = byp_sel_q ? byp_data_q : rf_ReadData_i;
`else
    assign r_rdata = rf_ReadData_i;
`endif

    assign bus.gnt_o     = gnt;
    assign bus.r_valid_o = r_valid;
    assign bus.r_rdata_o = r_rdata;

endmodule

// File: tb/tb_scm_1r1w_port_arbiter.sv
// Directed bench for scm_1r1w_port_arbiter (N_PORTS=4, ADDR_WIDTH=5,
// DATA_WIDTH=32). A cycle table covers write rotation, read latency,
// concurrent read/write, the address collision and fairness; a hand-written
// sequence covers reset in the middle of a read.
module tb_scm_1r1w_port_arbiter;

    localparam int NP = 4;
    localparam int AW = 5;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    scm_1r1w_port_arbiter_if #(.N_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    logic          rf_re, rf_we;
    logic [AW-1:0] rf_raddr, rf_waddr;
    logic [DW-1:0] rf_rdata, rf_wdata;

    scm_1r1w_port_arbiter #(.N_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .bus              (bus.slave),
        .rf_ReadEnable_o  (rf_re),
        .rf_ReadAddr_o    (rf_raddr),
        .rf_ReadData_i    (rf_rdata),
        .rf_WriteEnable_o (rf_we),
        .rf_WriteAddr_o   (rf_waddr),
        .rf_WriteData_o   (rf_wdata)
    );

    // Register-file model: the read samples the array at the grant edge, so a
    // same-edge write is not seen by that read. Contents survive reset.
    logic [DW-1:0] rf_mem [32];
    logic [DW-1:0] rf_rd_q;
    always @(posedge clk) begin
        if (rf_we) rf_mem[rf_waddr] <= rf_wdata;
        if (rf_re) rf_rd_q <= rf_mem[rf_raddr];
    end
    assign rf_rdata = rf_rd_q;

    typedef struct {
        logic [NP-1:0]    req;
        logic [NP-1:0]    we;
        logic [NP*AW-1:0] addr;
        logic [NP*DW-1:0] wdata;
        logic [NP-1:0]    gnt;
        logic [NP-1:0]    rvalid;
        logic [DW-1:0]    rdata;
    } vec_t;

    localparam int NV = 24;
    vec_t vt [NV];

    localparam logic [NP*AW-1:0] A_ALL = {5'd3, 5'd2, 5'd1, 5'd0};
    localparam logic [NP*DW-1:0] D_ALL = {32'hA3, 32'hA2, 32'hA1, 32'hA0};

    int n_vec = 0;
    int n_err = 0;
    int gcnt [NP];

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [NP-1:0] req, input logic [NP-1:0] we,
                         input logic [NP*AW-1:0] addr, input logic [NP*DW-1:0] wdata);
        bus.req_i   = req;
        bus.we_i    = we;
        bus.addr_i  = addr;
        bus.wdata_i = wdata;
    endtask

    initial begin
        // Test 1: all four ports write 0xA0+p to address p simultaneously.
        vt[0] = '{4'b1111, 4'b1111, A_ALL, D_ALL, 4'b0001, 4'b0000, 32'h0};
        vt[1] = '{4'b1110, 4'b1111, A_ALL, D_ALL, 4'b0010, 4'b0000, 32'h0};
        vt[2] = '{4'b1100, 4'b1111, A_ALL, D_ALL, 4'b0100, 4'b0000, 32'h0};
        vt[3] = '{4'b1000, 4'b1111, A_ALL, D_ALL, 4'b1000, 4'b0000, 32'h0};
        // Test 2: port 2 reads address 2, valid one cycle after grant.
        vt[4] = '{4'b0100, 4'b0000, {5'd0, 5'd2, 5'd0, 5'd0}, '0, 4'b0100, 4'b0000, 32'h0};
        vt[5] = '{4'b0000, 4'b0000, '0, '0, 4'b0000, 4'b0100, 32'hA2};
        // Test 3: port 0 writes 0x55 @7 while port 1 reads @3.
        vt[6] = '{4'b0011, 4'b0001, {5'd0, 5'd0, 5'd3, 5'd7}, {96'h0, 32'h55}, 4'b0011, 4'b0000, 32'h0};
        vt[7] = '{4'b0000, 4'b0000, '0, '0, 4'b0000, 4'b0010, 32'hA3};
        // Test 4: port 0 writes 0x1234 @9 while port 3 reads @9.
`ifdef SCM_ARB_RAW_BYPASS_EN
        vt[8]  = '{4'b1001, 4'b0001, {5'd9, 5'd0, 5'd0, 5'd9}, {96'h0, 32'h1234}, 4'b1001, 4'b0000, 32'h0};
        vt[9]  = '{4'b0000, 4'b0000, '0, '0, 4'b0000, 4'b1000, 32'h1234};
        vt[10] = '{4'b0000, 4'b0000, '0, '0, 4'b0000, 4'b0000, 32'h0};
`else
        vt[8]  = '{4'b1001, 4'b0001, {5'd9, 5'd0, 5'd0, 5'd9}, {96'h0, 32'h1234}, 4'b0001, 4'b0000, 32'h0};
        vt[9]  = '{4'b1000, 4'b0000, {5'd9, 5'd0, 5'd0, 5'd0}, '0, 4'b1000, 4'b0000, 32'h0};
        vt[10] = '{4'b0000, 4'b0000, '0, '0, 4'b0000, 4'b1000, 32'h1234};
`endif
        // Test 5: all ports read continuously for 12 cycles (port p reads @p).
        for (int i = 11; i < 23; i++) begin
            vt[i] = '{4'b1111, 4'b0000, A_ALL, '0, 4'(1 << ((i - 11) % 4)), 4'b0000, 32'h0};
            if (i > 11) begin
                vt[i].rvalid = 4'(1 << ((i - 12) % 4));
                vt[i].rdata  = 32'hA0 + 32'((i - 12) % 4);
            end
        end
        vt[23] = '{4'b0000, 4'b0000, '0, '0, 4'b0000, 4'b1000, 32'hA3};
        for (int p = 0; p < NP; p++) gcnt[p] = 0;

        // Reset state.
        rst_n = 1'b0;
        drive('0, '0, '0, '0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_gnt",     32'(bus.gnt_o),     32'h0);
        check("reset_r_valid", 32'(bus.r_valid_o), 32'h0);
        check("reset_rf_we",   32'(rf_we),         32'h0);
        check("reset_rf_re",   32'(rf_re),         32'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Table-driven cycles.
        for (int i = 0; i < NV; i++) begin
            drive(vt[i].req, vt[i].we, vt[i].addr, vt[i].wdata);
            @(negedge clk);
            check($sformatf("v%0d_gnt", i),     32'(bus.gnt_o),     32'(vt[i].gnt));
            check($sformatf("v%0d_r_valid", i), 32'(bus.r_valid_o), 32'(vt[i].rvalid));
            if (vt[i].rvalid != '0)
                check($sformatf("v%0d_r_rdata", i), bus.r_rdata_o, vt[i].rdata);
            if (i == 0) begin
                check("v0_rf_waddr", 32'(rf_waddr), 32'h0);
                check("v0_rf_wdata", rf_wdata,      32'hA0);
            end
            if (i >= 11 && i <= 22)
                for (int p = 0; p < NP; p++) gcnt[p] += int'(bus.gnt_o[p]);
            @(posedge clk);
            #1;
        end
        for (int p = 0; p < NP; p++)
            check($sformatf("fair_cnt_p%0d", p), 32'(gcnt[p]), 32'd3);

        // Test 6: reset in the cycle after a read grant.
        drive(4'b0010, 4'b0000, {5'd0, 5'd0, 5'd2, 5'd0}, '0);
        @(negedge clk);
        check("rst6_gnt", 32'(bus.gnt_o), 32'h2);
        @(posedge clk);
        #1;
        drive('0, '0, '0, '0);
        rst_n = 1'b0;
        #1;
        check("rst6_r_valid_async", 32'(bus.r_valid_o), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check($sformatf("rst6_no_valid_%0d", c), 32'(bus.r_valid_o), 32'h0);
            @(posedge clk);
            #1;
        end
        // Pointer back at 0: port 1 beats port 3 (a stale pointer of 2 would pick 3).
        drive(4'b1010, 4'b0000, {5'd3, 5'd0, 5'd2, 5'd0}, '0);
        @(negedge clk);
        check("rst6_ptr_gnt", 32'(bus.gnt_o), 32'h2);
        @(posedge clk);
        #1;
        drive(4'b1000, 4'b0000, {5'd3, 5'd0, 5'd0, 5'd0}, '0);
        @(negedge clk);
        check("rst6_gnt_p3",   32'(bus.gnt_o),     32'h8);
        check("rst6_r_valid1", 32'(bus.r_valid_o), 32'h2);
        check("rst6_r_rdata1", bus.r_rdata_o,      32'hA2);
        @(posedge clk);
        #1;
        drive('0, '0, '0, '0);
        @(negedge clk);
        check("rst6_r_valid3", 32'(bus.r_valid_o), 32'h8);
        check("rst6_r_rdata3", bus.r_rdata_o,      32'hA3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/scm_1r1w_port_arbiter.md
Name: scm_1r1w_port_arbiter

Overview:
Shares one 1-read/1-write latch-based register file among N_PORTS single-channel requesters, such as HWCE streamers and cores. Each cycle it grants at most one write and at most one read, using independent round-robin pointers. It drives the register-file port signals and returns read data with a per-port valid one cycle after grant. It resolves same-cycle read/write address collisions, because the latch array updates mid-cycle.

Parameters:
N_PORTS, 4, number of requesters (2..16)
ADDR_WIDTH, 5, register-file address width
DATA_WIDTH, 32, word width

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
req_i  input  N_PORTS  per-port request
we_i  input  N_PORTS  per-port op: 1 = write, 0 = read
addr_i  input  N_PORTS*ADDR_WIDTH  per-port address; port p uses slice [p*ADDR_WIDTH +: ADDR_WIDTH]
wdata_i  input  N_PORTS*DATA_WIDTH  per-port write data
gnt_o  output  N_PORTS  per-port grant, combinational, same cycle as req
r_valid_o  output  N_PORTS  one-hot read-data valid
r_rdata_o  output  DATA_WIDTH  read data, shared by all ports
rf_ReadEnable_o  output  1  to register file
rf_ReadAddr_o  output  ADDR_WIDTH  to register file
rf_ReadData_i  input  DATA_WIDTH  from register file
rf_WriteEnable_o  output  1  to register file
rf_WriteAddr_o  output  ADDR_WIDTH  to register file
rf_WriteData_o  output  DATA_WIDTH  to register file

Behaviour:
- Clock and reset: the single clock is clk; reset is rst_n, asynchronous and active-low.
- Reset values:
  - rd_ptr = 0, wr_ptr = 0.
  - r_valid_o = 0; rid_q = 0; r_rdata_o = rf_ReadData_i, meaningless while r_valid_o = 0.
  - gnt_o and rf_* are combinational; they are 0 whenever req_i = 0.
- Request hold: a requester holds req, we, addr and wdata stable until it sees gnt. A transfer completes on a cycle with req & gnt.
- Write arbitration:
  - Candidates are ports with req & we.
  - Round-robin: the first candidate at or after wr_ptr, modulo N_PORTS.
  - On grant of port w: rf_WriteEnable_o = 1, rf_WriteAddr_o/rf_WriteData_o taken from port w, wr_ptr <= (w+1) mod N_PORTS.
  - With no grant, wr_ptr holds.
- Read arbitration:
  - Candidates are ports with req & ~we, excluding any port whose address equals the granted write address this cycle (collision mask).
  - Round-robin from rd_ptr; rd_ptr advances past the winner as for writes.
  - On grant of port r: rf_ReadEnable_o = 1, rf_ReadAddr_o = addr of r.
- Read latency is exactly 1: r_valid_o[rid_q] = 1 in the cycle after a read grant, and r_rdata_o = rf_ReadData_i in that cycle. Reads are back-to-back capable, one per cycle.
- Write visibility: a write granted in cycle t is visible to a read granted in cycle t+1 or later.
- Collision, same cycle, same address: the write wins. The read is not granted and retries; it is granted next cycle if still highest eligible. Other read candidates may be granted in the collision cycle.
- Throughput: one read and one write to different addresses are both granted in the same cycle.
- Reset mid-operation: a pending r_valid is dropped and pointers return to 0. The register-file contents are unaffected.
- State: two round-robin pointers of clog2(N_PORTS) bits, a registered read-valid and read-id, plus optional bypass registers. There is no FSM beyond this.

Optional Feature:
SCM_ARB_RAW_BYPASS_EN
- Defined: a same-cycle, same-address read is not masked; it is granted alongside the write.
  - The write data is captured in byp_data_q and byp_sel_q is set.
  - In the next cycle r_rdata_o = byp_data_q instead of rf_ReadData_i.
  - Read latency remains 1.
- Undefined: the collision mask applies as above, and the bypass registers are absent.

Test Plan:
(N_PORTS=4, ADDR_WIDTH=5, DATA_WIDTH=32)
1. Reset → all ports write once: rst_n low then high; ports 0..3 each request a write of 0xA0+p to address p, all simultaneously → grants go to p0, p1, p2, p3 in consecutive cycles; wr_ptr = 0 afterwards.
2. Read-back latency: port 2 reads address 2 the cycle after test 1 finishes → r_valid_o = 4'b0100 exactly one cycle after gnt, with r_rdata_o = 0x000000A2.
3. Concurrent read and write: port 0 writes 0x55 to address 7 while port 1 reads address 3 (holding 0xA3), same cycle → both granted; next cycle r_valid_o[1] = 1 with data 0xA3.
4. Collision, macro undefined: port 0 writes 0x1234 to address 9 while port 3 reads address 9, same cycle → port 3 is not granted that cycle. Port 3 is granted the next cycle and returns 0x1234.
   Collision, macro defined: the read is granted in the same cycle and returns 0x1234 one cycle later.
5. Fairness: all 4 ports read continuously for 12 cycles → each port is granted exactly 3 times, in rotation 0, 1, 2, 3.
6. Reset mid-operation: assert rst_n low in the cycle after a read grant → r_valid_o = 0 and no valid is issued after release; a subsequent read of the same address returns the stored value.
